// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 issue controller and its response FIFO.
package fma16_pkg;

  localparam int FMA16_WIDTH = 16;

  typedef struct packed {
    logic mul;
    logic add;
    logic negp;
    logic negz;
  } fma16_op_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fma16_flags_t;

endpackage

// File: rtl/fma16_rsp_fifo.sv
// Circular response FIFO with an occupancy count output; DEPTH must be a power of two.
module fma16_rsp_fifo
  import fma16_pkg::*;
#(
  parameter int WIDTH = FMA16_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Upstream credit accounting must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/fma16_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency fma16 core between NREQ requesters.
// Optional perf counters (perf_issued, perf_stall) are enabled by defining FMA16_ISSUE_CTRL_PERF_EN.
module fma16_issue_ctrl
  import fma16_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [FMA16_WIDTH*NREQ-1:0]  req_x,
  input  logic [FMA16_WIDTH*NREQ-1:0]  req_y,
  input  logic [FMA16_WIDTH*NREQ-1:0]  req_z,
  input  logic [4*NREQ-1:0]            req_op,
  output logic                         core_valid,
  output logic [FMA16_WIDTH-1:0]       core_x,
  output logic [FMA16_WIDTH-1:0]       core_y,
  output logic [FMA16_WIDTH-1:0]       core_z,
  output logic [3:0]                   core_op,
  input  logic [FMA16_WIDTH-1:0]       core_result,
  input  logic [3:0]                   core_flags,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [FMA16_WIDTH-1:0]       rsp_result,
  output logic [3:0]                   rsp_flags
`ifdef FMA16_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = IDW + FMA16_WIDTH + 4;

  logic [FMA16_WIDTH-1:0] lane_x  [NREQ];
  logic [FMA16_WIDTH-1:0] lane_y  [NREQ];
  logic [FMA16_WIDTH-1:0] lane_z  [NREQ];
  fma16_op_t              lane_op [NREQ];

  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  search_idx;
  logic [NREQ-1:0] grant;
  logic            credit_ok;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;

  logic            tag_v  [LATENCY];
  logic [IDW-1:0]  tag_id [LATENCY];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head_data;
  fma16_flags_t    head_flags;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_x[i]  = req_x[i*FMA16_WIDTH +: FMA16_WIDTH];
    assign lane_y[i]  = req_y[i*FMA16_WIDTH +: FMA16_WIDTH];
    assign lane_z[i]  = req_z[i*FMA16_WIDTH +: FMA16_WIDTH];
    assign lane_op[i] = fma16_op_t'(req_op[i*4 +: 4]);
  end

  // Holding reset_n in the credit term keeps req_ready low while reset is asserted.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = reset_n && (credit_used < (CW+1)'(FIFO_DEPTH));

  // Walk downward so the lowest offset from rr with a valid request wins.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    search_idx = '0;
    if (credit_ok && |req_valid) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        search_idx = IDW'((int'(rr) + k) % NREQ);
        if (req_valid[search_idx]) grant_id = search_idx;
      end
      grant[grant_id] = 1'b1;
    end
  end

  assign req_ready  = grant;
  assign core_valid = |grant;
  assign core_x     = core_valid ? lane_x[grant_id] : '0;
  assign core_y     = core_valid ? lane_y[grant_id] : '0;
  assign core_z     = core_valid ? lane_z[grant_id] : '0;
  assign core_op    = core_valid ? lane_op[grant_id] : '0;

  assign push      = tag_v[LATENCY-1];
  assign push_data = {tag_id[LATENCY-1], core_result, core_flags};
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr       <= '0;
      inflight <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      if (core_valid) rr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
      tag_v[0]  <= core_valid;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      case ({core_valid, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  fma16_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_data),
    .rdata   (head_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // Head fields read as zero when empty so stale storage never reaches the outputs.
  assign head_flags = fma16_flags_t'(head_data[3:0]);
  assign rsp_valid  = !fifo_empty;
  assign rsp_id     = rsp_valid ? head_data[EW-1 -: IDW] : '0;
  assign rsp_result = rsp_valid ? head_data[4 +: FMA16_WIDTH] : '0;
  assign rsp_flags  = rsp_valid ? head_flags : '0;

`ifdef FMA16_ISSUE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (core_valid && perf_issued != '1) perf_issued <= perf_issued + 1'b1;
      if (|req_valid && !core_valid && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  // Perf counters compiled out.
`endif

endmodule

// File: tb/tb_fma16_issue_ctrl.sv
// Directed bench for fma16_issue_ctrl with a behavioural fixed-latency core and a response scoreboard.
module tb_fma16_issue_ctrl;
  import fma16_pkg::*;

  localparam int NREQ       = 2;
  localparam int LATENCY    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = $clog2(NREQ);

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [16*NREQ-1:0]          req_x, req_y, req_z;
  logic [4*NREQ-1:0]           req_op;
  logic                        core_valid;
  logic [15:0]                 core_x, core_y, core_z;
  logic [3:0]                  core_op;
  logic [15:0]                 core_result;
  logic [3:0]                  core_flags;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [15:0]                 rsp_result;
  logic [3:0]                  rsp_flags;
`ifdef FMA16_ISSUE_CTRL_PERF_EN
  logic [31:0]                 perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  fma16_issue_ctrl #(.NREQ(NREQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op),
    .core_valid(core_valid), .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_op(core_op),
    .core_result(core_result), .core_flags(core_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef FMA16_ISSUE_CTRL_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  // Stand-in core: exact for 1.0*y+0, an operand hash otherwise; flags derived from result and op.
  function automatic logic [19:0] core_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic [3:0] op);
    logic [15:0] r;
    if (x == 16'h3C00 && z == 16'h0000) r = y;
    else r = x ^ {y[7:0], y[15:8]} ^ z ^ {op, 12'h000};
    return {r, r[3:0] ^ op};
  endfunction

  logic [19:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_valid ? core_model(core_x, core_y, core_z, core_op) : {16'hDEAD, 4'hF};
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_result = core_pipe[LATENCY-1][19:4];
  assign core_flags  = core_pipe[LATENCY-1][3:0];

  int vectors = 0;
  int miscompares = 0;
  logic [IDW+19:0] sb_q [$];
  int accept_log [$];
  int rsp_log [$];
  int issued;
  int stall_cycles;
  logic [NREQ-1:0] accepted;
  logic            seen_rsp_valid;
  logic            seen_ready_any;
  logic [IDW-1:0]  seen_id;
  logic [15:0]     seen_result;
  logic [15:0] lane_x [NREQ];
  logic [15:0] lane_y [NREQ];
  logic [15:0] lane_z [NREQ];
  logic [3:0]  lane_op [NREQ];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic packLanes();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*16 +: 16] = lane_x[i];
      req_y[i*16 +: 16] = lane_y[i];
      req_z[i*16 +: 16] = lane_z[i];
      req_op[i*4 +: 4]  = lane_op[i];
    end
  endtask

  task automatic newOperands(input int i);
    lane_x[i]  = 16'($urandom);
    lane_y[i]  = 16'($urandom);
    lane_z[i]  = 16'($urandom);
    lane_op[i] = 4'($urandom_range(0, 15));
  endtask

  // Scoreboard: accepted requests push expectations; popped responses are compared in order.
  task automatic monitorCycle();
    logic [IDW+19:0] exp;
    accepted       = req_valid & req_ready;
    seen_ready_any = |req_ready;
    checkOutput("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    checkOutput("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i]) begin
        checkOutput("core_x", 32'(core_x), 32'(lane_x[i]));
        checkOutput("core_op", 32'(core_op), 32'(lane_op[i]));
        sb_q.push_back({IDW'(i), core_model(lane_x[i], lane_y[i], lane_z[i], lane_op[i])});
        accept_log.push_back(i);
        issued++;
      end
    end
    if (|req_valid && !(|accepted)) stall_cycles++;
    seen_rsp_valid = rsp_valid;
    seen_id        = rsp_id;
    seen_result    = rsp_result;
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp = sb_q.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp[IDW+19:20]));
        checkOutput("rsp_result", 32'(rsp_result), 32'(exp[19:4]));
        checkOutput("rsp_flags", 32'(rsp_flags), 32'(exp[3:0]));
        rsp_log.push_back(int'(rsp_id));
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    @(negedge clk);
    monitorCycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (accepted[i]) newOperands(i);
    packLanes();
  endtask

  task automatic clearModel();
    sb_q.delete();
    accept_log.delete();
    rsp_log.delete();
    issued       = 0;
    stall_cycles = 0;
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    clearModel();
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) applyStimulus('0, 1'b1);
    checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    for (int i = 0; i < NREQ; i++) newOperands(i);
    packLanes();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #12;
    req_valid = '1;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_core_valid", 32'(core_valid), 32'd0);
    checkOutput("reset_core_x", 32'(core_x), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("[TB] single op latency");
    lane_x[0] = 16'h3C00; lane_y[0] = 16'h4000; lane_z[0] = 16'h0000; lane_op[0] = 4'b1100;
    packLanes();
    applyStimulus(2'b01, 1'b1);
    checkOutput("single_accept", 32'(accepted), 32'h1);
    for (int k = 1; k <= LATENCY; k++) begin
      applyStimulus(2'b00, 1'b1);
      checkOutput("single_early_rsp", 32'(seen_rsp_valid), 32'd0);
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("single_rsp_valid", 32'(seen_rsp_valid), 32'd1);
    checkOutput("single_rsp_id", 32'(seen_id), 32'd0);
    checkOutput("single_rsp_result", 32'(seen_result), 32'h4000);
    drain();

    $display("[TB] round-robin alternation");
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(2'b11, 1'b1);
    drain();
    checkOutput("rr_accept_count", 32'(accept_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < accept_log.size(); k++)
      checkOutput("rr_grant_order", 32'(accept_log[k]), 32'(k % 2));
    for (int k = 0; k < 6 && k < rsp_log.size(); k++)
      checkOutput("rr_rsp_order", 32'(rsp_log[k]), 32'(k % 2));

    $display("[TB] credit stall under backpressure");
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(2'b01, 1'b0);
    checkOutput("stall_accepts", 32'(issued), 32'd4);
    checkOutput("stall_ready_low", 32'(seen_ready_any), 32'd0);
    applyStimulus(2'b01, 1'b1);
    checkOutput("stall_pop_no_bypass", 32'(accepted), 32'd0);
    applyStimulus(2'b01, 1'b0);
    checkOutput("stall_accept_after_pop", 32'(accepted), 32'h1);
    for (int k = 0; k < 4; k++) applyStimulus(2'b01, 1'b0);
    checkOutput("stall_total_accepts", 32'(issued), 32'd5);
    drain();

    $display("[TB] push/pop overlap and pointer wrap");
    doReset();
    applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b11, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(2'b00, 1'b0);
    checkOutput("wrap_prefill", 32'(issued), 32'd2);
    for (int k = 0; k < 30; k++) applyStimulus(2'b11, 1'((k % 3) != 0));
    drain();
    checkOutput("wrap_ops_gt8", 32'(issued > 8), 32'd1);

    $display("[TB] reset mid-operation");
    doReset();
    applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b11, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b11, 1'b0);
    checkOutput("midreset_queued", 32'(issued), 32'd4);
    rsp_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset_core_valid", 32'(core_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clearModel();
    for (int k = 0; k < LATENCY + 2; k++) begin
      applyStimulus(2'b00, 1'b1);
      checkOutput("midreset_stale_ignored", 32'(seen_rsp_valid), 32'd0);
    end
    applyStimulus(2'b10, 1'b1);
    checkOutput("midreset_new_accept", 32'(accepted), 32'h2);
    drain();
    checkOutput("midreset_new_rsp", 32'(rsp_log.size()), 32'd1);

`ifdef FMA16_ISSUE_CTRL_PERF_EN
    $display("[TB] perf counters");
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(2'b01, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(2'b11, 1'((k % 2) == 0));
    applyStimulus(2'b00, 1'b1);
    checkOutput("perf_issued", perf_issued, 32'(issued));
    checkOutput("perf_stall", perf_stall, 32'(stall_cycles));
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
